// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding and baud-divider helper.
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  // Rounded clock-to-baud ratio; callers need the result to be at least 4.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_writer_if.sv
// Serial-line and FIFO-push signal bundle between the UART receiver and the byte FIFO side.
interface uart_rx_fifo_writer_if #(
  parameter int unsigned BUS_WIDTH = 8
);

  logic                 rx;
  logic                 fifo_full;
  logic                 fifo_push;
  logic [BUS_WIDTH-1:0] fifo_din;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    input  rx,
    input  fifo_full,
    output fifo_push,
    output fifo_din,
    output frame_err,
    output overrun,
    output busy
  );

  modport slave (
    output rx,
    output fifo_full,
    input  fifo_push,
    input  fifo_din,
    input  frame_err,
    input  overrun,
    input  busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with a parameterised reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_fifo_writer.sv
// UART receiver (1 start, BUS_WIDTH data LSB-first, 1 stop) that pushes good frames into a byte FIFO.
module uart_rx_fifo_writer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned BUS_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_rx_fifo_writer_if.master  bus
);

  localparam int unsigned CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam int unsigned IDX_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CPB_M1   = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUS_WIDTH - 1);

  uart_rx_state_t       state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [BUS_WIDTH-1:0] shreg_q;
  logic [BUS_WIDTH-1:0] din_q;
  logic                 push_q;
  logic                 ferr_q;
  logic                 ovr_q;
  logic                 busy_q;
  logic                 rx_s;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start after reset.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk    (clk),
    .rst_ni (reset),
    .d_i    (bus.rx),
    .q_o    (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= WAIT_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      din_q     <= '0;
      push_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      case (state_q)
        WAIT_IDLE: begin
          if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            busy_q  <= 1'b1;
          end
        end
        IDLE: begin
          if (!rx_s) begin
            cnt_q   <= '0;
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            if (!rx_s) begin
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CPB_M1) begin
            cnt_q              <= '0;
            shreg_q[bit_idx_q] <= rx_s;
            if (bit_idx_q == LAST_IDX) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CPB_M1) begin
            cnt_q <= '0;
            // fifo_full is judged on the same edge as the stop sample, so a push never lands on a full FIFO.
            if (rx_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              if (bus.fifo_full) begin
                ovr_q <= 1'b1;
              end else begin
                push_q <= 1'b1;
                din_q  <= shreg_q;
              end
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= WAIT_IDLE;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.fifo_push = push_q;
  assign bus.fifo_din  = din_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = busy_q;

endmodule
